// File: rtl/interpolate_inverse_if.sv
// Request/result bundle for the inverse linear interpolator.
// The master drives start and the operands; the slave returns Tk with status.
interface interpolate_inverse_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] Tn;
    logic [WIDTH-1:0] Tz;
    logic [WIDTH-1:0] Un;
    logic [WIDTH-1:0] Uz;
    logic [WIDTH-1:0] Uk;
    logic [WIDTH-1:0] Tk;
    logic             error;
    logic             ready;
    logic             busy;

    modport master (
        output start, Tn, Tz, Un, Uz, Uk,
        input  Tk, error, ready, busy
    );

    modport slave (
        input  start, Tn, Tz, Un, Uz, Uk,
        output Tk, error, ready, busy
    );
endinterface

// File: rtl/interpolate_inverse.sv
// Sequential inverse linear interpolator: Tk = Tn + (Uk-Un)*(Tz-Tn)/(Uz-Un).
// Registered multiply, bit-serial restoring divide, fixed 2*WIDTH+3 edge latency.
module interpolate_inverse #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    interpolate_inverse_if.slave bus
);
    localparam int CW    = $clog2(2 * WIDTH);
    localparam int QFRAC = 2 * FRAC - FRAC;
    localparam logic [2*WIDTH-1:0] POS_LIM = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic [2*WIDTH-1:0] NEG_LIM = {{WIDTH{1'b0}}, 1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [WIDTH-1:0]   SMAX    = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0]   SMIN    = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_SUB, S_MUL, S_DIV, S_ADD} state_t;

    state_t                    state_q, state_d;
    logic signed [WIDTH-1:0]   tn_q, tn_d, tz_q, tz_d, un_q, un_d, uz_q, uz_d, uk_q, uk_d;
    logic signed [WIDTH-1:0]   du_q, du_d, dt_q, dt_d, dd_q, dd_d;
    logic [2*WIDTH-1:0]        num_q, num_d, quot_q, quot_d;
    logic [WIDTH-1:0]          rem_q, rem_d, div_q, div_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      sign_q, sign_d, dz_q, dz_d, fault_q, fault_d;
    logic [WIDTH-1:0]          tk_q, tk_d;
    logic                      error_q, error_d, ready_q, ready_d, busy_q, busy_d;

    logic signed [WIDTH-1:0]   sub_du, sub_dt, sub_dd;
    logic signed [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0]        p_mag, q_mag;
    logic [WIDTH-1:0]          dd_mag, q_sat;
    logic [WIDTH:0]            shift_v, diff_v;
    logic signed [WIDTH:0]     sum;
    logic                      q_ovf, add_ovf;

    function automatic logic sub_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic [WIDTH-1:0] d);
        return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
    endfunction

    always_comb begin
        state_d = state_q;
        tn_d = tn_q; tz_d = tz_q; un_d = un_q; uz_d = uz_q; uk_d = uk_q;
        du_d = du_q; dt_d = dt_q; dd_d = dd_q;
        num_d = num_q; quot_d = quot_q; rem_d = rem_q; div_d = div_q;
        cnt_d = cnt_q; sign_d = sign_q; dz_d = dz_q; fault_d = fault_q;
        tk_d = tk_q; error_d = error_q; busy_d = busy_q;
        ready_d = 1'b0;

        sub_du  = uk_q - un_q;
        sub_dt  = tz_q - tn_q;
        sub_dd  = uz_q - un_q;
        prod    = du_q * dt_q;
        p_mag   = prod[2*WIDTH-1] ? -prod : prod;
        dd_mag  = dd_q[WIDTH-1] ? -dd_q : dd_q;
        shift_v = {rem_q, num_q[2*WIDTH-1]};
        diff_v  = shift_v - {1'b0, div_q};

        // Product has 2*FRAC fraction bits, divisor FRAC, so the quotient is already aligned.
        q_mag = dz_q ? '0 : (quot_q >> (QFRAC - FRAC));
        q_ovf = 1'b0;
        if (!sign_q && q_mag > POS_LIM) begin
            q_sat = SMAX;
            q_ovf = 1'b1;
        end else if (sign_q && q_mag > NEG_LIM) begin
            q_sat = SMIN;
            q_ovf = 1'b1;
        end else begin
            q_sat = sign_q ? -q_mag[WIDTH-1:0] : q_mag[WIDTH-1:0];
        end
        sum     = {tn_q[WIDTH-1], tn_q} + {q_sat[WIDTH-1], q_sat};
        add_ovf = sum[WIDTH] != sum[WIDTH-1];

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    tn_d = bus.Tn; tz_d = bus.Tz; un_d = bus.Un; uz_d = bus.Uz; uk_d = bus.Uk;
                    busy_d  = 1'b1;
                    fault_d = 1'b0;
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                du_d    = sub_du;
                dt_d    = sub_dt;
                dd_d    = sub_dd;
                dz_d    = (sub_dd == '0);
                fault_d = fault_q | sub_ovf(uk_q, un_q, sub_du) | sub_ovf(tz_q, tn_q, sub_dt)
                          | sub_ovf(uz_q, un_q, sub_dd) | (sub_dd == '0);
                state_d = S_MUL;
            end
            S_MUL: begin
                num_d   = p_mag;
                div_d   = dd_mag;
                rem_d   = '0;
                quot_d  = '0;
                sign_d  = prod[2*WIDTH-1] ^ dd_q[WIDTH-1];
                cnt_d   = CW'(2 * WIDTH - 1);
                state_d = S_DIV;
            end
            S_DIV: begin
                // No borrow out of the trial subtraction means the divisor fits.
                if (!diff_v[WIDTH]) begin
                    rem_d  = diff_v[WIDTH-1:0];
                    quot_d = {quot_q[2*WIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = shift_v[WIDTH-1:0];
                    quot_d = {quot_q[2*WIDTH-2:0], 1'b0};
                end
                num_d = num_q << 1;
                if (cnt_q == '0) state_d = S_ADD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_ADD: begin
                tk_d    = add_ovf ? (sum[WIDTH] ? SMIN : SMAX) : sum[WIDTH-1:0];
                error_d = fault_q | q_ovf | add_ovf;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tn_q <= '0; tz_q <= '0; un_q <= '0; uz_q <= '0; uk_q <= '0;
            du_q <= '0; dt_q <= '0; dd_q <= '0;
            num_q <= '0; quot_q <= '0; rem_q <= '0; div_q <= '0;
            cnt_q <= '0; sign_q <= 1'b0; dz_q <= 1'b0; fault_q <= 1'b0;
            tk_q <= '0; error_q <= 1'b0; ready_q <= 1'b0; busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tn_q <= tn_d; tz_q <= tz_d; un_q <= un_d; uz_q <= uz_d; uk_q <= uk_d;
            du_q <= du_d; dt_q <= dt_d; dd_q <= dd_d;
            num_q <= num_d; quot_q <= quot_d; rem_q <= rem_d; div_q <= div_d;
            cnt_q <= cnt_d; sign_q <= sign_d; dz_q <= dz_d; fault_q <= fault_d;
            tk_q <= tk_d; error_q <= error_d; ready_q <= ready_d; busy_q <= busy_d;
        end
    end

    assign bus.Tk    = tk_q;
    assign bus.error = error_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
endmodule
